// File: rtl/lcd_spi_pkg.sv
// -----------------------------------------------------------------------------
// lcd_spi_pkg
// Shared definitions for the LCD serial link receiver:
//   - state_t     : receiver FSM state encoding (IDLE, SHIFT)
//   - LCD_WORD_W  : width of one link word, {dc, byte}
//   - sample_on_rising() : sampling-edge select from CPOL/CPHA
// -----------------------------------------------------------------------------
package lcd_spi_pkg;

   localparam int LCD_WORD_W = 9;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Data is sampled on the rising sclk edge when CPOL == CPHA, else falling.
   function automatic logic sample_on_rising(input logic cpol, input logic cpha);
      return (cpol == cpha);
   endfunction

endpackage

// File: rtl/lcd_spi_sync.sv
// -----------------------------------------------------------------------------
// lcd_spi_sync
// Multi-flop synchronizer for one asynchronous pin.
// Parameters: STAGES (flop depth, min 2), RST_VAL (value loaded on reset).
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   i_d    : asynchronous input pin
//   o_q    : synchronized output (STAGES cycles of delay)
// -----------------------------------------------------------------------------
module lcd_spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_q;

   // Shift chain; bit 0 is the metastability-catching flop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= {STAGES{RST_VAL}};
      end else begin
         r_q <= {r_q[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/lcd_spi_rx.sv
// -----------------------------------------------------------------------------
// lcd_spi_rx
// Responder end of the 9-bit LCD command/data SPI link. Synchronizes cs, dc,
// sclk and mosi, shifts one byte MSB-first per eight sampling edges, captures
// dc on the first edge and presents {dc, byte} to a valid/ready consumer.
// Optional build macro: LCD_SPI_RX_FIFO_EN replaces the single holding
// register with a FIFO_DEPTH-entry first-word-fall-through FIFO.
// Ports:
//   sys_clk_50MHz : system clock
//   sys_rst       : synchronous active-high reset
//   cs, dc, sclk, mosi : asynchronous SPI pins (cs active low)
//   rx_ready      : consumer accepts rx_data
//   rx_data       : {dc, byte}
//   rx_valid      : rx_data holds an unconsumed word
//   overflow      : one-cycle pulse, a completed word was dropped
//   frame_err     : one-cycle pulse, cs rose with 1-7 bits shifted
// -----------------------------------------------------------------------------
module lcd_spi_rx
   import lcd_spi_pkg::*;
#(
   parameter logic CPOL        = 1'b0,
   parameter logic CPHA        = 1'b0,
   parameter int   SYNC_STAGES = 2,
   parameter int   FIFO_DEPTH  = 4
) (
   input  logic                  sys_clk_50MHz,
   input  logic                  sys_rst,
   input  logic                  cs,
   input  logic                  dc,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  rx_ready,
   output logic [LCD_WORD_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  overflow,
   output logic                  frame_err
);

   localparam logic SAMPLE_RISE = sample_on_rising(CPOL, CPHA);

   logic w_cs, w_dc, w_sclk, w_mosi, w_edge;
   logic r_sclk_d;

   state_t                r_state, w_state_nx;
   logic [2:0]            r_bit_cnt, w_bit_cnt_nx;
   logic [7:0]            r_shift, w_shift_nx;
   logic                  r_dc, w_dc_nx;
   logic                  r_push, w_push_nx;
   logic [LCD_WORD_W-1:0] r_word, w_word_nx;
   logic                  r_ferr, w_ferr_nx;
   logic                  r_frame_err;

   // Idle-high reset on cs and sclk so reset never looks like a frame start.
   lcd_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.i_clk(sys_clk_50MHz), .i_rst(sys_rst), .i_d(cs),   .o_q(w_cs));
   lcd_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc   (.i_clk(sys_clk_50MHz), .i_rst(sys_rst), .i_d(dc),   .o_q(w_dc));
   lcd_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (.i_clk(sys_clk_50MHz), .i_rst(sys_rst), .i_d(sclk), .o_q(w_sclk));
   lcd_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.i_clk(sys_clk_50MHz), .i_rst(sys_rst), .i_d(mosi), .o_q(w_mosi));

   assign w_edge = SAMPLE_RISE ? (w_sclk & ~r_sclk_d) : (~w_sclk & r_sclk_d);

   // FSM state and shift datapath registers.
   always_ff @(posedge sys_clk_50MHz) begin
      if (sys_rst) begin
         r_state   <= IDLE;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'd0;
         r_dc      <= 1'b0;
         r_push    <= 1'b0;
         r_word    <= {LCD_WORD_W{1'b0}};
         r_ferr    <= 1'b0;
         r_sclk_d  <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_bit_cnt <= w_bit_cnt_nx;
         r_shift   <= w_shift_nx;
         r_dc      <= w_dc_nx;
         r_push    <= w_push_nx;
         r_word    <= w_word_nx;
         r_ferr    <= w_ferr_nx;
         r_sclk_d  <= w_sclk;
      end
   end

   // Next-state and shift logic; a cs rise takes priority over a coincident edge.
   always_comb begin
      w_state_nx   = r_state;
      w_bit_cnt_nx = r_bit_cnt;
      w_shift_nx   = r_shift;
      w_dc_nx      = r_dc;
      w_push_nx    = 1'b0;
      w_word_nx    = r_word;
      w_ferr_nx    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_cs) begin
               w_bit_cnt_nx = 3'd0;
               w_state_nx   = SHIFT;
            end else begin
               w_state_nx   = IDLE;
            end
         end
         SHIFT: begin
            if (w_cs) begin
               w_ferr_nx    = (r_bit_cnt != 3'd0);
               w_bit_cnt_nx = 3'd0;
               w_state_nx   = IDLE;
            end else if (w_edge) begin
               w_shift_nx   = {r_shift[6:0], w_mosi};
               w_bit_cnt_nx = r_bit_cnt + 3'd1;   // 7 -> 0 wrap closes the word
               if (r_bit_cnt == 3'd0) begin
                  w_dc_nx = w_dc;
               end else begin
                  w_dc_nx = r_dc;
               end
               if (r_bit_cnt == 3'd7) begin
                  w_push_nx = 1'b1;
                  w_word_nx = {r_dc, w_shift_nx};
               end else begin
                  w_push_nx = 1'b0;
               end
            end else begin
               w_state_nx = SHIFT;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   // Registered frame-error pulse.
   always_ff @(posedge sys_clk_50MHz) begin
      if (sys_rst) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= r_ferr;
      end
   end

   assign frame_err = r_frame_err;

`ifdef LCD_SPI_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [LCD_WORD_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]           r_wr_ptr, r_rd_ptr;
   logic                  r_ovf;
   logic                  w_full, w_empty, w_pop, w_wr_en;

   // Extra wrap bit distinguishes full from empty when the indices match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = !w_empty && rx_ready;
   assign w_wr_en = r_push && (!w_full || w_pop);

   // FIFO storage, pointers and overflow pulse.
   always_ff @(posedge sys_clk_50MHz) begin
      if (sys_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= {LCD_WORD_W{1'b0}};
         end
         r_wr_ptr <= {(AW+1){1'b0}};
         r_rd_ptr <= {(AW+1){1'b0}};
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_word;
            r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         r_ovf <= r_push && !w_wr_en;
      end
   end

   assign rx_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign rx_valid = !w_empty;
   assign overflow = r_ovf;
`else
   logic [LCD_WORD_W-1:0] r_rx_data;
   logic                  r_rx_valid;
   logic                  r_ovf;

   // FIFO_DEPTH only shapes the FIFO build.
   if (FIFO_DEPTH < 1) begin : g_depth_unused
   end

   // Single holding register; a word arriving while the consumer takes the
   // old one replaces it, otherwise a word onto a held one is dropped.
   always_ff @(posedge sys_clk_50MHz) begin
      if (sys_rst) begin
         r_rx_data  <= {LCD_WORD_W{1'b0}};
         r_rx_valid <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (r_push) begin
         if (!r_rx_valid || rx_ready) begin
            r_rx_data  <= r_word;
            r_rx_valid <= 1'b1;
            r_ovf      <= 1'b0;
         end else begin
            r_ovf      <= 1'b1;
         end
      end else begin
         if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end else begin
            r_rx_valid <= r_rx_valid;
         end
         r_ovf <= 1'b0;
      end
   end

   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_lcd_spi_rx
// Scoreboard bench: two receivers (mode 0 and CPOL=1/CPHA=1) driven by an SPI
// writer model; expected words are queued at stimulus time and a monitor pops
// them on every rx_valid && rx_ready handshake.
// -----------------------------------------------------------------------------
module tb_lcd_spi_rx;
   import lcd_spi_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic cs_p [2];
   logic dc_p [2];
   logic sclk_p [2];
   logic mosi_p [2];
   logic rdy_p [2];
   logic [LCD_WORD_W-1:0] data_p [2];
   logic valid_p [2];
   logic ovf_p [2];
   logic ferr_p [2];

   lcd_spi_rx #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut0 (
      .sys_clk_50MHz(clk), .sys_rst(rst), .cs(cs_p[0]), .dc(dc_p[0]), .sclk(sclk_p[0]),
      .mosi(mosi_p[0]), .rx_ready(rdy_p[0]), .rx_data(data_p[0]), .rx_valid(valid_p[0]),
      .overflow(ovf_p[0]), .frame_err(ferr_p[0]));

   lcd_spi_rx #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut3 (
      .sys_clk_50MHz(clk), .sys_rst(rst), .cs(cs_p[1]), .dc(dc_p[1]), .sclk(sclk_p[1]),
      .mosi(mosi_p[1]), .rx_ready(rdy_p[1]), .rx_data(data_p[1]), .rx_valid(valid_p[1]),
      .overflow(ovf_p[1]), .frame_err(ferr_p[1]));

   int cyc = 0;
   int n_total = 0;
   int n_pass = 0;
   int ferr_cnt [2] = '{0, 0};
   int ovf_cnt [2] = '{0, 0};
   int last_edge [2] = '{0, 0};
   logic prev_valid [2] = '{1'b0, 1'b0};
   logic [LCD_WORD_W-1:0] exp_q0 [$];
   logic [LCD_WORD_W-1:0] exp_q1 [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // Monitor: latency on each rx_valid rise, scoreboard pop on handshake.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            if (valid_p[d] && !prev_valid[d]) chk("latency", cyc - last_edge[d], 4);
            if (valid_p[d] && rdy_p[d]) begin
               if (d == 0) begin
                  if (exp_q0.size() == 0) chk("unexpected_word0", 32'(data_p[d]), -1);
                  else chk("word0", 32'(data_p[d]), 32'(exp_q0.pop_front()));
               end else begin
                  if (exp_q1.size() == 0) chk("unexpected_word1", 32'(data_p[d]), -1);
                  else chk("word1", 32'(data_p[d]), 32'(exp_q1.pop_front()));
               end
            end
            if (ferr_p[d]) ferr_cnt[d]++;
            if (ovf_p[d]) ovf_cnt[d]++;
         end
         prev_valid[d] = valid_p[d];
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cs_low(input int d, input logic dcv);
      cs_p[d] = 1'b0;
      dc_p[d] = dcv;
      tick(5);
   endtask

   task automatic cs_high(input int d);
      tick(5);
      cs_p[d] = 1'b1;
      tick(12);
   endtask

   // Device 0 is mode 0 (sample rising, idle low); device 1 is mode 3.
   task automatic send_bit(input int d, input logic b);
      if (d == 0) begin
         mosi_p[d] = b;
         tick(5);
         sclk_p[d] = 1'b1;
         last_edge[d] = cyc;
         tick(5);
         sclk_p[d] = 1'b0;
      end else begin
         sclk_p[d] = 1'b0;
         mosi_p[d] = b;
         tick(5);
         sclk_p[d] = 1'b1;
         last_edge[d] = cyc;
         tick(5);
      end
   endtask

   task automatic send_byte(input int d, input logic [7:0] b, input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(d, b[7-i]);
   endtask

   task automatic frame0(input logic dcv, input logic [7:0] b);
      cs_low(0, dcv);
      send_byte(0, b, 8);
      cs_high(0);
   endtask

   task automatic drain0();
      for (int k = 0; k < 60 && exp_q0.size() != 0; k++) tick(1);
      chk("drain_timeout", exp_q0.size(), 0);
   endtask

   initial begin
      int fe;
      rst = 1'b1;
      cs_p = '{1'b1, 1'b1};
      dc_p = '{1'b0, 1'b0};
      sclk_p = '{1'b0, 1'b1};
      mosi_p = '{1'b0, 1'b0};
      rdy_p = '{1'b1, 1'b1};
      tick(3);
      chk("reset_rx_data", 32'(data_p[0]), 0);
      chk("reset_rx_valid", 32'(valid_p[0]), 0);
      chk("reset_overflow", 32'(ovf_p[0]), 0);
      chk("reset_frame_err", 32'(ferr_p[0]), 0);
      rst = 1'b0;
      tick(5);

      // Basic word, dc = 1.
      exp_q0.push_back(9'h1A5);
      frame0(1'b1, 8'hA5);
      chk("basic_drained", exp_q0.size(), 0);
      chk("basic_no_ferr", ferr_cnt[0], 0);

      // Partial frame then a clean byte.
      cs_low(0, 1'b0);
      send_byte(0, 8'h3C, 5);
      cs_high(0);
      chk("partial_ferr", ferr_cnt[0], 1);
      exp_q0.push_back(9'h03C);
      frame0(1'b0, 8'h3C);
      chk("after_partial_drained", exp_q0.size(), 0);
      chk("after_partial_ferr", ferr_cnt[0], 1);

      // Back-pressure and overflow.
      rdy_p[0] = 1'b0;
`ifndef LCD_SPI_RX_FIFO_EN
      exp_q0.push_back(9'h011);
      frame0(1'b0, 8'h11);
      frame0(1'b0, 8'h22);
      chk("ovf_held_data", 32'(data_p[0]), 32'h011);
      chk("ovf_held_valid", 32'(valid_p[0]), 1);
      chk("ovf_count", ovf_cnt[0], 1);
`else
      for (int i = 1; i <= 4; i++) exp_q0.push_back(9'(i));
      for (int i = 1; i <= 5; i++) frame0(1'b0, 8'(i));
      chk("ovf_head_data", 32'(data_p[0]), 32'h001);
      chk("ovf_count", ovf_cnt[0], 1);
`endif
      rdy_p[0] = 1'b1;
      drain0();
      tick(3);
      chk("drained_valid", 32'(valid_p[0]), 0);
      chk("ovf_count_final", ovf_cnt[0], 1);

      // Reset in the middle of a byte.
      cs_low(0, 1'b1);
      send_byte(0, 8'hF0, 4);
      fe = ferr_cnt[0];
      rst = 1'b1;
      tick(2);
      chk("midrst_rx_data", 32'(data_p[0]), 0);
      chk("midrst_rx_valid", 32'(valid_p[0]), 0);
      chk("midrst_overflow", 32'(ovf_p[0]), 0);
      chk("midrst_frame_err", 32'(ferr_p[0]), 0);
      cs_p[0] = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(5);
      exp_q0.push_back(9'h0F0);
      frame0(1'b0, 8'hF0);
      chk("post_rst_drained", exp_q0.size(), 0);
      chk("post_rst_no_ferr", ferr_cnt[0], fe);

      // Mode 3, two bytes in one cs window.
      exp_q1.push_back(9'h080);
      exp_q1.push_back(9'h001);
      cs_low(1, 1'b0);
      send_byte(1, 8'h80, 8);
      send_byte(1, 8'h01, 8);
      cs_high(1);
      chk("mode3_drained", exp_q1.size(), 0);
      chk("mode3_no_ferr", ferr_cnt[1], 0);
      chk("mode3_no_ovf", ovf_cnt[1], 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
